data_c_pipe_intc_m2s_pkt_id: RTL

//  NUM-source to 1-sink valid/ready interconnect with packet lock and ID tagging.

---
 rtl/data_c_pipe_intc_m2s_pkt_id.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_c_pipe_intc_m2s_pkt_id.sv
// NUM-source to 1-sink valid/ready interconnect with optional packet lock and
// per-beat source ID tagging, feeding a 2-entry registered output FIFO.
module data_c_pipe_intc_m2s_pkt_id #(
   parameter int NUM      = 8,
   parameter int DSIZE    = 32,
   parameter int IDSIZE   = 4,
   parameter     PRIO     = "ROBIN",
   parameter int LOCK_PKT = 1
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic [NUM*DSIZE-1:0]     s_data,
   input  logic [NUM*IDSIZE-1:0]    s_id,
   input  logic [NUM-1:0]           s_last,
   input  logic [NUM-1:0]           s_valid,
   output logic [NUM-1:0]           s_ready,
   output logic [DSIZE-1:0]         m_data,
   output logic [IDSIZE-1:0]        m_id,
   output logic [$clog2(NUM)-1:0]   m_sidx,
   output logic                     m_last,
   output logic                     m_valid,
   input  logic                     m_ready
);

   // Handshake: a beat moves on a port in any cycle where valid and ready are
   // both high; s_ready depends only on registered state and s_valid, never on m_ready.

   localparam int ISIZE = $clog2(NUM);
   localparam bit FIXED = (PRIO == "FIXED");
   localparam int EW    = 1 + ISIZE + IDSIZE + DSIZE;

   typedef logic [ISIZE-1:0] idx_t;

   logic [EW-1:0] buf_q [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic          lock;
   idx_t          lock_idx;
   idx_t          rr_ptr;

   idx_t          gnt;
   logic          gnt_vld;
   logic          space;
   logic          accept;
   logic          pop;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head;
   int            cand;

   // Grant selection; loops run far-to-near so the nearest candidate is assigned last.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      cand    = 0;
      if (lock) begin
         gnt     = lock_idx;
         gnt_vld = 1'b1;
      end else if (FIXED) begin
         for (int i = NUM - 1; i >= 0; i--) begin
            if (s_valid[idx_t'(i)]) begin
               gnt     = idx_t'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = NUM; k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % NUM;
            if (s_valid[idx_t'(cand)]) begin
               gnt     = idx_t'(cand);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      space   = (count != 2'd2);
      s_ready = '0;
      if (gnt_vld && space) begin
         s_ready[gnt] = 1'b1;
      end
      accept     = gnt_vld && space && s_valid[gnt];
      pop        = (count != 2'd0) && m_ready;
      push_entry = {s_last[gnt], gnt, s_id[gnt*IDSIZE +: IDSIZE], s_data[gnt*DSIZE +: DSIZE]};
   end

   assign head    = buf_q[rd_ptr];
   assign m_valid = (count != 2'd0);
   assign m_data  = head[DSIZE-1:0];
   assign m_id    = head[DSIZE +: IDSIZE];
   assign m_sidx  = head[DSIZE+IDSIZE +: ISIZE];
   assign m_last  = head[EW-1];

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         lock     <= 1'b0;
         lock_idx <= '0;
         rr_ptr   <= idx_t'(NUM - 1);
      end else begin
         if (accept) begin
            buf_q[wr_ptr] <= push_entry;
            wr_ptr        <= ~wr_ptr;
            if (!FIXED) begin
               rr_ptr <= gnt;
            end
            // A last beat always releases; only a non-last beat can take the lock.
            if (s_last[gnt]) begin
               lock <= 1'b0;
            end else if (LOCK_PKT != 0) begin
               lock     <= 1'b1;
               lock_idx <= gnt;
            end
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
